// File: rtl/inst_sequencer_pkg.sv
// Shared opcodes, instruction fields and FSM states
// for the calculator instruction sequencer.
package inst_sequencer_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 2;
  localparam int RC_HI  = 1;
  localparam int RC_LO  = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_ISSUE,
    S_GAP,
    S_FIN
  } state_t;

  function automatic logic is_send(
    input logic [7:0] inst
  );
    return inst[OP_HI:OP_LO] == OP_SEND;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 8, one write port, sync read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_sequencer.sv
// Replays stored instructions as inst_vld/inst_wd strobes,
// spaced GAP+2 cycles apart; SENDs wait for tx_busy low.
// Ports: clk, rst (async high), prog_we/addr/data/len,
// start, abort, tx_busy -> inst_vld, inst_wd, busy, done, pc.
// Build option INST_SEQUENCER_SINGLE_STEP_EN adds step and
// step_mode: GAP then also waits for a step rising edge.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic          tx_busy,
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
  input  logic          step,
  input  logic          step_mode,
`endif
  output logic          inst_vld,
  output logic [7:0]    inst_wd,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  localparam int GW = $clog2(GAP);

  state_t          state;
  logic [AW:0]     len;
  logic [GW-1:0]   gcnt;
  logic [AW-1:0]   raddr;
  logic [7:0]      rdata;
  logic            mem_we;
  logic            cnt_done;
  logic            last;
  logic            go;

  assign mem_we   = prog_we && (state == S_IDLE);
  assign cnt_done = gcnt == GW'(GAP - 1);
  assign last     = {1'b0, pc} == (len - 1'b1);

`ifdef INST_SEQUENCER_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      step_q <= 1'b0;
    else
      step_q <= step;
  end

  // Only an edge seen after the count finished counts.
  assign go = !step_mode || (step && !step_q);
`else
  assign go = 1'b1;
`endif

  // Address the word the next state will need, so the
  // opcode is already readable while in FETCH.
  always_comb begin
    raddr = pc;
    unique case (1'b1)
      (state == S_IDLE): raddr = '0;
      (state == S_GAP):  raddr = pc + 1'b1;
      default:           raddr = pc;
    endcase
  end

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      inst_vld <= 1'b0;
      inst_wd  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc       <= '0;
      gcnt     <= '0;
      len      <= '0;
    end else begin
      inst_vld <= 1'b0;
      done     <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              len  <= prog_len;
              busy <= 1'b1;
              if (prog_len == '0) begin
                state <= S_FIN;
              end else begin
                pc    <= '0;
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (is_send(rdata) && tx_busy)
              state <= S_HOLD;
            else
              state <= S_ISSUE;
          end
          S_HOLD: begin
            if (!tx_busy)
              state <= S_ISSUE;
          end
          S_ISSUE: begin
            inst_vld <= 1'b1;
            inst_wd  <= rdata;
            gcnt     <= '0;
            state    <= S_GAP;
          end
          S_GAP: begin
            if (!cnt_done) begin
              gcnt <= gcnt + 1'b1;
            end else if (go) begin
              if (last) begin
                state <= S_FIN;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: run timing, SEND hold,
// empty run, abort, async reset, write lockout, step mode.
module tb_inst_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tx_busy = 1'b0;
  logic          step = 1'b0;
  logic          step_mode = 1'b0;
  logic          inst_vld;
  logic [7:0]    inst_wd;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0;
  int x;
  int q_t[$];
  logic [7:0] q_w[$];
  int done_n = 0;
  int done_t = 0;
  logic busy_h [0:4095];
  logic [7:0] prog [0:5] = '{8'h04, 8'h00, 8'h13,
                             8'h86, 8'h63, 8'hC0};

  inst_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .abort     (abort),
    .tx_busy   (tx_busy),
`ifdef INST_SEQUENCER_SINGLE_STEP_EN
    .step      (step),
    .step_mode (step_mode),
`endif
    .inst_vld  (inst_vld),
    .inst_wd   (inst_wd),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inst_vld) begin
      q_t.push_back(cyc);
      q_w.push_back(inst_wd);
    end
    if (done) begin
      done_n++;
      done_t = cyc;
    end
    if (cyc < 4096)
      busy_h[cyc] = busy;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int qt(input int i);
    return (i < q_t.size()) ? q_t[i] - t0 : -999;
  endfunction

  function automatic logic [7:0] qw(input int i);
    return (i < q_w.size()) ? q_w[i] : 8'hxx;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q_t.delete();
    q_w.delete();
    done_n = 0;
  endtask

  task automatic go(input int len);
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_n == 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(done_n > 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("rst_vld", inst_vld, 0);
    check("rst_wd", inst_wd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc, 0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      prog_we = 1'b1;
      prog_addr = AW'(i);
      prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;
    tick(2);

    // Normal run; prog_len change after start ignored
    clear();
    go(6);
    prog_len = 2;
    wait_done("r1");
    check("r1_n", q_t.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("r1_w%0d", i), qw(i), prog[i]);
      check($sformatf("r1_t%0d", i), qt(i), 2 + 6 * i);
    end
    check("r1_done_t", done_t - t0, 37);
    check("r1_done_n", done_n, 1);
    check("r1_busy_fin", busy_h[done_t - 1], 1);
    check("r1_busy_dn", busy_h[done_t], 0);
    check("r1_pc", pc, 5);
    tick(3);

    // SEND held while the transmitter is busy
    clear();
    go(6);
    while (cyc < t0 + 30) tick();
    tx_busy = 1'b1;
    tick(49);
    check("hold_n", q_t.size(), 5);
    check("hold_busy", busy, 1);
    tick();
    tx_busy = 1'b0;
    wait_done("hold");
    check("hold_n6", q_t.size(), 6);
    check("hold_t4", qt(4), 26);
    check("hold_t5", qt(5), 82);
    check("hold_w5", qw(5), 8'hC0);
    check("hold_done", done_t - t0, 87);
    tick(3);

    // Empty program
    clear();
    go(0);
    tick(4);
    check("len0_n", q_t.size(), 0);
    check("len0_dn", done_n, 1);
    check("len0_dt", done_t - t0, 1);
    check("len0_b0", busy_h[t0], 1);
    check("len0_b1", busy_h[t0 + 1], 0);

    // Abort after the third strobe
    clear();
    go(6);
    while (cyc < t0 + 15) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_pc", pc, 2);
    tick(40);
    check("ab_n", q_t.size(), 3);
    check("ab_done", done_n, 0);
    clear();
    go(6);
    wait_done("ab_re");
    check("ab_re_n", q_t.size(), 6);
    check("ab_re_w0", qw(0), 8'h04);
    tick(3);

    // Asynchronous reset mid-run
    clear();
    go(6);
    while (cyc < t0 + 14) tick();
    check("ar_pre_vld", inst_vld, 1);
    check("ar_pre_wd", inst_wd, 8'h13);
    #1 rst = 1'b1;
    #1;
    check("ar_vld", inst_vld, 0);
    check("ar_wd", inst_wd, 0);
    check("ar_busy", busy, 0);
    check("ar_pc", pc, 0);
    check("ar_done", done, 0);
    #2 rst = 1'b0;
    tick(3);

    // Writes during a run are dropped
    clear();
    go(6);
    tick(3);
    prog_we = 1'b1;
    prog_addr = '0;
    prog_data = 8'hFF;
    tick();
    prog_we = 1'b0;
    wait_done("we1");
    clear();
    go(6);
    wait_done("we2");
    check("we_w0", qw(0), 8'h04);
    tick(3);

    // start with abort in IDLE
    clear();
    prog_len = 6;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    tick(10);
    check("sa_n", q_t.size(), 0);
    check("sa_done", done_n, 0);

`ifdef INST_SEQUENCER_SINGLE_STEP_EN
    clear();
    step_mode = 1'b1;
    go(6);
    tick(2);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(12);
    check("st_early", q_t.size(), 1);
    step = 1'b1;
    x = cyc;
    tick();
    step = 1'b0;
    tick(4);
    check("st_n2", q_t.size(), 2);
    check("st_t2", qt(1) + t0 - x, 3);
    tick(3);
    step = 1'b1;
    x = cyc;
    tick();
    step = 1'b0;
    tick(4);
    check("st_n3", q_t.size(), 3);
    check("st_t3", qt(2) + t0 - x, 3);
    step_mode = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("st_ab", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
